mca_acq_ctrl: RTL

Acquisition sequencer downstream of the AXI4-Lite control register slave: it converts the start/stop/clear command pulses and preset register from that slave into histogram-clear sweeps, a histogram accumulate enable, and real/live-time counters. Its status, real-time and live-time outputs are wired back into the slave's read-only registers. It also drives the clear port of the spectrum histogram RAM.

---
 rtl/mca_acq_pkg.sv | 16 +
 rtl/mca_tick_prescaler.sv | 32 +++
 rtl/mca_acq_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mca_acq_pkg.sv
// Shared types and defaults for the MCA acquisition sequencer.
// Build option: MCA_ACQ_LIVE_TIME_EN enables the live-time counter.
package mca_acq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } acq_state_t;

    localparam int unsigned CNT_W_DEF    = 32;
    localparam int unsigned ADDR_W_DEF   = 10;
    localparam int unsigned TICK_DIV_DEF = 100000;

endpackage

// File: rtl/mca_tick_prescaler.sv
// Divides enabled clock cycles down to one tick per TICK_DIV cycles.
// The tick is combinational so the owner's counter steps on the wrap edge.
module mca_tick_prescaler
    import mca_acq_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;

    assign tick = en && !clr && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mca_acq_ctrl.sv
// Acquisition sequencer: clear sweeps, histogram enable, real/live time.
// Build option: MCA_ACQ_LIVE_TIME_EN adds the live-time prescaler/counter.
module mca_acq_ctrl
    import mca_acq_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              ctrl_start,
    input  logic              ctrl_stop,
    input  logic              ctrl_clear,
    input  logic [CNT_W-1:0]  preset_time,
    input  logic              dead,
    output logic [ADDR_W-1:0] hist_clr_addr,
    output logic              hist_clr_we,
    output logic              hist_en,
    output logic [CNT_W-1:0]  real_time,
    output logic [CNT_W-1:0]  live_time,
    output logic [1:0]        acq_state,
    output logic              done,
    output logic              irq
);

    acq_state_t        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic              en_q;
    logic              done_q;
    logic              irq_q;
    logic [CNT_W-1:0]  real_q;
    logic [CNT_W-1:0]  live_q;

    logic running;
    logic restart;
    logic pres_clr;
    logic preset_hit;
    logic tick_real;

    assign running    = (state_q == RUN);
    assign restart    = (state_q == DONE) && ctrl_start
                        && !ctrl_stop && !ctrl_clear;
    // Counters and prescalers restart together on clear or rerun from DONE
    assign pres_clr   = ctrl_clear || restart;
    assign preset_hit = running && (preset_time != '0)
                        && (real_q >= preset_time);

    mca_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_real (
        .clk  (ACLK),
        .rst_n(ARESETN),
        .en   (running),
        .clr  (pres_clr),
        .tick (tick_real)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            real_q <= '0;
        end else if (pres_clr) begin
            real_q <= '0;
        end else if (tick_real && (real_q != '1)) begin
            real_q <= real_q + 1'b1;
        end
    end

`ifdef MCA_ACQ_LIVE_TIME_EN
    logic tick_live;

    mca_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_live (
        .clk  (ACLK),
        .rst_n(ARESETN),
        .en   (running && !dead),
        .clr  (pres_clr),
        .tick (tick_live)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            live_q <= '0;
        end else if (pres_clr) begin
            live_q <= '0;
        end else if (tick_live && (live_q != '1)) begin
            live_q <= live_q + 1'b1;
        end
    end
`else
    logic unused_dead;
    assign unused_dead = dead;
    assign live_q      = '0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (ctrl_clear) begin
                state_q <= CLEAR;
                addr_q  <= '0;
                we_q    <= 1'b1;
                en_q    <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (ctrl_start && !ctrl_stop) begin
                            state_q <= RUN;
                            en_q    <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        if (addr_q == '1) begin
                            state_q <= IDLE;
                            addr_q  <= '0;
                            we_q    <= 1'b0;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                    RUN: begin
                        if (ctrl_stop) begin
                            state_q <= IDLE;
                            en_q    <= 1'b0;
                        end else if (preset_hit) begin
                            state_q <= DONE;
                            en_q    <= 1'b0;
                            done_q  <= 1'b1;
                            irq_q   <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (restart) begin
                            state_q <= RUN;
                            en_q    <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign hist_clr_addr = addr_q;
    assign hist_clr_we   = we_q;
    assign hist_en       = en_q;
    assign real_time     = real_q;
    assign live_time     = live_q;
    assign acq_state     = state_q;
    assign done          = done_q;
    assign irq           = irq_q;

endmodule
